fwd_arb_ctrl: RTL and testbench

Forwarding arbiter/sequencer for the parallel-core output path. It grants the shared forwarding mux tree to one of N packet-filter cores at a time, round-robin, and holds the grant for a whole packet. It drives the mux tree select tag and emits valid/last strobes delayed to line up with the tree's registered output. Sits in fwd_arb beside the mux tree; cores raise req when they hold an accepted packet.

---
 rtl/fwd_arb_ctrl.sv | 147 ++++++++++++++
 tb/tb_fwd_arb_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_arb_ctrl.sv
// Forwarding arbiter/sequencer for the parallel-core output path.
// Grants the shared forwarding mux tree to one core at a time, round-robin,
// holds the grant for a whole packet, and emits valid/last strobes delayed
// to line up with the registered output of the mux tree.
module fwd_arb_ctrl #(
    parameter int N      = 4,
    parameter int TAG_SZ = 2,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      done,
    output logic [N-1:0]      gnt,
    output logic [TAG_SZ-1:0] sel,
    output logic              busy,
    output logic              fwd_valid,
    output logic              fwd_last
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     ptr_nxt;
    logic [IW-1:0]     cur;
    logic [IW-1:0]     cur_nxt;
    logic [N-1:0]      gnt_nxt;
    logic [TAG_SZ-1:0] sel_nxt;
    logic              busy_nxt;
    logic              found;
    logic [IW-1:0]     win;
    logic              acc_done;
    logic [LAT-1:0]    valid_sr;
    logic [LAT-1:0]    last_sr;

    // Only the granted core's done counts; gnt is zero outside GRANT, so a
    // done arriving on the grant-issuing edge is naturally ignored.
    assign acc_done = |(done & gnt);

    // Round-robin scan: first requester at ptr, ptr+1, ... wrapping modulo N.
    always_comb begin
        int            s;
        logic [IW-1:0] idx;
        found = 1'b0;
        win   = '0;
        s     = 0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            s = int'(ptr) + i;
            if (s >= N) begin
                s = s - N;
            end
            idx = IW'(s);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT/GAP sequencer.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cur_nxt   = cur;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = GRANT;
                    gnt_nxt      = '0;
                    gnt_nxt[win] = 1'b1;
                    sel_nxt      = TAG_SZ'(win);
                    cur_nxt      = win;
                    busy_nxt     = 1'b1;
                end
            end
            GRANT: begin
                if (acc_done) begin
                    state_nxt = GAP;
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = (cur == IW'(N - 1)) ? '0 : cur + IW'(1);
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, pointer and grant registers; reset drops any packet in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            cur   <= '0;
            gnt   <= '0;
            sel   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cur   <= cur_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            busy  <= busy_nxt;
        end
    end

    // Delay lines matching the mux tree depth for the valid and last strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else begin
            valid_sr[0] <= busy;
            last_sr[0]  <= acc_done;
            for (int i = 1; i < LAT; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    assign fwd_valid = valid_sr[LAT-1];
    assign fwd_last  = last_sr[LAT-1];

    // The grant vector must never carry more than one set bit.
    gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));

endmodule

// File: tb/tb_fwd_arb_ctrl.sv
// Bench for fwd_arb_ctrl: a 4-core LAT=1 instance and a 5-core LAT=2
// instance driven from a table of per-cycle vectors through a scoreboard.
module tb_fwd_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req4;
    logic [3:0] done4;
    logic [3:0] gnt4;
    logic [1:0] sel4;
    logic       busy4;
    logic       fv4;
    logic       fl4;
    logic [4:0] req5;
    logic [4:0] done5;
    logic [4:0] gnt5;
    logic [3:0] sel5;
    logic       busy5;
    logic       fv5;
    logic       fl5;

    int checks   = 0;
    int failures = 0;
    int row_id   = 0;

    typedef struct {
        bit         use5;
        bit         do_reset;
        logic [7:0] req;
        logic [7:0] done;
        logic [7:0] gnt;
        logic [3:0] sel;
        logic       busy;
        logic       fv;
        logic       fl;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    fwd_arb_ctrl #(.N(4), .TAG_SZ(2), .LAT(1)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req       (req4),
        .done      (done4),
        .gnt       (gnt4),
        .sel       (sel4),
        .busy      (busy4),
        .fwd_valid (fv4),
        .fwd_last  (fl4)
    );

    fwd_arb_ctrl #(.N(5), .TAG_SZ(4), .LAT(2)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .req       (req5),
        .done      (done5),
        .gnt       (gnt5),
        .sel       (sel5),
        .busy      (busy5),
        .fwd_valid (fv5),
        .fwd_last  (fl5)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(bit u5, bit rs, logic [7:0] rq, logic [7:0] dn,
                                logic [7:0] gn, logic [3:0] sl,
                                logic b, logic v, logic l);
        vec_t r;
        r.use5     = u5;
        r.do_reset = rs;
        r.req      = rq;
        r.done     = dn;
        r.gnt      = gn;
        r.sel      = sl;
        r.busy     = b;
        r.fv       = v;
        r.fl       = l;
        return r;
    endfunction

    task automatic check_val(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL row%0d %s: got %h required %h", row_id, name, act, exp);
        end
    endtask

    task automatic check_dut4_zero(string tag);
        check_val({tag, " gnt4"},  {4'b0, gnt4},  8'h00);
        check_val({tag, " sel4"},  {6'b0, sel4},  8'h00);
        check_val({tag, " busy4"}, {7'b0, busy4}, 8'h00);
        check_val({tag, " fv4"},   {7'b0, fv4},   8'h00);
        check_val({tag, " fl4"},   {7'b0, fl4},   8'h00);
    endtask

    // Hold reset across one rising edge; outputs must clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        req4  = '0;
        done4 = '0;
        req5  = '0;
        done5 = '0;
        #1;
        check_dut4_zero("reset");
        check_val("reset gnt5",  {3'b0, gnt5},  8'h00);
        check_val("reset sel5",  {4'b0, sel5},  8'h00);
        check_val("reset busy5", {7'b0, busy5}, 8'h00);
        check_val("reset fv5",   {7'b0, fv5},   8'h00);
        check_val("reset fl5",   {7'b0, fl5},   8'h00);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_output();
        vec_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL row%0d scoreboard: got empty required entry", row_id);
            return;
        end
        checks--;
        e = sb.pop_front();
        if (e.use5) begin
            check_val("gnt5",  {3'b0, gnt5},  e.gnt);
            check_val("sel5",  {4'b0, sel5},  {4'b0, e.sel});
            check_val("busy5", {7'b0, busy5}, {7'b0, e.busy});
            check_val("fv5",   {7'b0, fv5},   {7'b0, e.fv});
            check_val("fl5",   {7'b0, fl5},   {7'b0, e.fl});
        end else begin
            check_val("gnt4",  {4'b0, gnt4},  e.gnt);
            check_val("sel4",  {6'b0, sel4},  {4'b0, e.sel});
            check_val("busy4", {7'b0, busy4}, {7'b0, e.busy});
            check_val("fv4",   {7'b0, fv4},   {7'b0, e.fv});
            check_val("fl4",   {7'b0, fl4},   {7'b0, e.fl});
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic apply_stimulus(vec_t v);
        if (v.do_reset) begin
            do_reset();
        end
        @(negedge clk);
        row_id++;
        if (v.use5) begin
            req5  = v.req[4:0];
            done5 = v.done[4:0];
            req4  = '0;
            done4 = '0;
        end else begin
            req4  = v.req[3:0];
            done4 = v.done[3:0];
            req5  = '0;
            done5 = '0;
        end
        sb.push_back(v);
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        logic [7:0] oh;
        logic [3:0] sl;
        rst   = 1'b1;
        req4  = '0;
        done4 = '0;
        req5  = '0;
        done5 = '0;

        // Reset state, then single requester with a 4-cycle packet.
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h01, 8'h00, 8'h01, 4'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h01, 8'h00, 8'h01, 4'd0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h01, 8'h00, 8'h01, 4'd0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h01, 8'h00, 8'h01, 4'd0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h01, 8'h01, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0));

        // Fairness with all cores requesting: order 0,1,2,3,0.
        for (int g = 0; g < 5; g++) begin
            oh = 8'(1 << (g % 4));
            sl = 4'(g % 4);
            vecs.push_back(mk(1'b0, (g == 0), 8'h0F, 8'h00, oh, sl, 1'b1, 1'b0, 1'b0));
            vecs.push_back(mk(1'b0, 1'b0, 8'h0F, 8'h00, oh, sl, 1'b1, 1'b1, 1'b0));
            vecs.push_back(mk(1'b0, 1'b0, 8'h0F, 8'h00, oh, sl, 1'b1, 1'b1, 1'b0));
            vecs.push_back(mk(1'b0, 1'b0, 8'h0F, oh, 8'h00, sl, 1'b0, 1'b1, 1'b1));
            vecs.push_back(mk(1'b0, 1'b0, 8'h0F, 8'h00, 8'h00, sl, 1'b0, 1'b0, 1'b0));
        end

        // Spurious done on other cores is ignored; next grant goes to core 3.
        vecs.push_back(mk(1'b0, 1'b1, 8'h04, 8'h00, 8'h04, 4'd2, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h04, 8'h01, 8'h04, 4'd2, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h04, 8'h0B, 8'h04, 4'd2, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h04, 8'h04, 8'h00, 4'd2, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 8'h09, 8'h00, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h09, 8'h00, 8'h08, 4'd3, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h09, 8'h08, 8'h00, 4'd3, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0));

        // After core 2 with core 3 idle, the scan wraps to core 0.
        vecs.push_back(mk(1'b0, 1'b1, 8'h04, 8'h00, 8'h04, 4'd2, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h04, 8'h04, 8'h00, 4'd2, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h01, 8'h00, 8'h01, 4'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h01, 8'h01, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0));

        // Done on the grant-issuing edge is ignored; req drop keeps the grant.
        vecs.push_back(mk(1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 4'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h01, 8'h00, 8'h01, 4'd0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 4'd0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 4'd0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0));

        // N=5, LAT=2: park ptr at 4, grant core 4, then wrap to core 0.
        vecs.push_back(mk(1'b1, 1'b1, 8'h08, 8'h00, 8'h08, 4'd3, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h08, 8'h08, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 4'd3, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h11, 8'h00, 8'h10, 4'd4, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h11, 8'h00, 8'h10, 4'd4, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h11, 8'h10, 8'h00, 4'd4, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 4'd4, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h01, 8'h00, 8'h01, 4'd0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
        end

        // Async reset mid-packet: move ptr to 2, grant core 3, then reset.
        apply_stimulus(mk(1'b0, 1'b1, 8'h02, 8'h00, 8'h02, 4'd1, 1'b1, 1'b0, 1'b0));
        apply_stimulus(mk(1'b0, 1'b0, 8'h02, 8'h02, 8'h00, 4'd1, 1'b0, 1'b1, 1'b1));
        apply_stimulus(mk(1'b0, 1'b0, 8'h0A, 8'h00, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0));
        apply_stimulus(mk(1'b0, 1'b0, 8'h0A, 8'h00, 8'h08, 4'd3, 1'b1, 1'b0, 1'b0));
        apply_stimulus(mk(1'b0, 1'b0, 8'h0A, 8'h00, 8'h08, 4'd3, 1'b1, 1'b1, 1'b0));
        #2;
        rst  = 1'b0;
        req4 = '0;
        #1;
        row_id++;
        check_dut4_zero("midpkt");
        @(negedge clk);
        rst = 1'b1;
        // Pointer restarted at 0, so core 1 wins over core 3.
        apply_stimulus(mk(1'b0, 1'b0, 8'h0A, 8'h00, 8'h02, 4'd1, 1'b1, 1'b0, 1'b0));
        apply_stimulus(mk(1'b0, 1'b0, 8'h0A, 8'h02, 8'h00, 4'd1, 1'b0, 1'b1, 1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
